// File: rtl/add_loa_pkg.sv
// Shared constants and helpers for the pipelined lower-part-OR approximate adder.
// Holds the per-transaction error metric and the parameter legality predicate.
package add_loa_pkg;

  localparam logic MODE_EXACT = 1'b0;
  localparam logic MODE_LOA   = 1'b1;

  // |exact - approximate| for one LOA addition, from the K low operand bits only.
  function automatic logic [31:0] loa_abs_err(input logic [31:0] a_low,
                                              input logic [31:0] b_low,
                                              input int          k);
    logic [31:0] span;
    logic [31:0] d;
    if (k <= 0) return '0;
    span = 32'd1 << k;
    d    = a_low & b_low & (span - 32'd1);
    return d[k-1] ? (span - d) : d;
  endfunction

  function automatic bit params_legal(input int w, input int seg, input int k);
    return (seg > 0) && (w >= seg) && ((w % seg) == 0) && (k >= 0) && (k < w);
  endfunction

endpackage

// File: rtl/add_loa_seg.sv
// Combinational SEG-bit slice of the LOA adder: OR cells where masked, ripple elsewhere.
// The masked cell at global bit K-1 emits a&b as the carry into bit K.
module add_loa_seg
  import add_loa_pkg::*;
#(
  parameter int SEG  = 4,
  parameter int BASE = 0,
  parameter int K    = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic [SEG-1:0] approx_mask,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  // NOTE: every output of an always_comb gets a value before any branch, so no latch is inferred.
  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < SEG; i++) begin
      if (approx_mask[i]) begin
        sum[i] = a[i] | b[i];
        c      = (BASE + i == K - 1) ? (a[i] & b[i]) : 1'b0;
      end else begin
        sum[i] = a[i] ^ b[i] ^ c;
        c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
    end
    cout = c;
  end

endmodule

// File: rtl/add_loa_pipe.sv
// Pipelined LOA approximate adder, one SEG-bit slice per stage, with a single global
// stall enable and saturating error statistics collected at the output handshake.
module add_loa_pipe
  import add_loa_pkg::*;
#(
  parameter int W     = 8,
  parameter int K     = 4,
  parameter int SEG   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       out_sum,
  output logic             out_mode,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_cnt,
  output logic [W-1:0]     stat_wce
);

  localparam int P = W / SEG;

  if (!params_legal(W, SEG, K)) begin : g_param_check
    $fatal(1, "add_loa_pipe: W must be a multiple of SEG and K must lie in 0..W-1");
  end

  logic         en;
  logic [W-1:0] out_err;

  for (genvar s = 0; s < P; s++) begin : g_stage
    localparam int LO  = s * SEG;
    localparam int REM = W - LO - SEG;

    // Operands arrive already stripped of the bits consumed by earlier stages.
    logic [W-LO-1:0]   a_src, b_src;
    logic              vld_src, mode_src, cin_src;
    logic [W-1:0]      err_src;
    logic [SEG-1:0]    approx_mask, seg_sum;
    logic              seg_cout;
    logic [LO+SEG-1:0] sum_new;

    logic              vld_d, vld_q, mode_d, mode_q, cy_d, cy_q;
    logic [W-1:0]      err_d, err_q;
    logic [LO+SEG-1:0] sum_d, sum_q;

    if (s == 0) begin : g_src
      assign a_src    = in_a;
      assign b_src    = in_b;
      assign vld_src  = in_valid;
      assign mode_src = in_mode;
      assign cin_src  = 1'b0;
      assign err_src  = (in_mode == MODE_LOA) ? W'(loa_abs_err(32'(in_a), 32'(in_b), K)) : '0;
      assign sum_new  = seg_sum;
    end else begin : g_src
      assign a_src    = g_stage[s-1].g_ops.a_q;
      assign b_src    = g_stage[s-1].g_ops.b_q;
      assign vld_src  = g_stage[s-1].vld_q;
      assign mode_src = g_stage[s-1].mode_q;
      assign cin_src  = g_stage[s-1].cy_q;
      assign err_src  = g_stage[s-1].err_q;
      assign sum_new  = {seg_sum, g_stage[s-1].sum_q};
    end

    always_comb begin
      approx_mask = '0;
      for (int i = 0; i < SEG; i++) begin
        approx_mask[i] = (mode_src == MODE_LOA) && (LO + i < K);
      end
    end

    add_loa_seg #(
      .SEG  (SEG),
      .BASE (LO),
      .K    (K)
    ) u_seg (
      .a           (a_src[SEG-1:0]),
      .b           (b_src[SEG-1:0]),
      .approx_mask (approx_mask),
      .cin         (cin_src),
      .sum         (seg_sum),
      .cout        (seg_cout)
    );

    always_comb begin
      vld_d  = vld_q;
      mode_d = mode_q;
      cy_d   = cy_q;
      err_d  = err_q;
      sum_d  = sum_q;
      if (en) begin
        vld_d  = vld_src;
        mode_d = mode_src;
        cy_d   = seg_cout;
        err_d  = err_src;
        sum_d  = sum_new;
      end
    end

    // NOTE: state registers use non-blocking assignment so every stage samples pre-edge values.
    // NOTE: datapath registers are reset too, so out_sum/out_mode read 0 during reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        mode_q <= 1'b0;
        cy_q   <= 1'b0;
        err_q  <= '0;
        sum_q  <= '0;
      end else begin
        vld_q  <= vld_d;
        mode_q <= mode_d;
        cy_q   <= cy_d;
        err_q  <= err_d;
        sum_q  <= sum_d;
      end
    end

    if (REM > 0) begin : g_ops
      logic [REM-1:0] a_d, a_q, b_d, b_q;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (en) begin
          a_d = a_src[W-LO-1:SEG];
          b_d = b_src[W-LO-1:SEG];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign out_valid = g_stage[P-1].vld_q;
  assign out_mode  = g_stage[P-1].mode_q;
  assign out_sum   = {g_stage[P-1].cy_q, g_stage[P-1].sum_q};
  assign out_err   = g_stage[P-1].err_q;
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [W-1:0]     wce_d, wce_q;

  always_comb begin
    cnt_d = cnt_q;
    wce_d = wce_q;
    if (stat_clr) begin
      cnt_d = '0;
      wce_d = '0;
    end else if (out_valid && out_ready && (out_mode == MODE_LOA)) begin
      if ((out_err != '0) && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
      if (out_err > wce_q) wce_d = out_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      wce_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      wce_q <= wce_d;
    end
  end

  assign stat_cnt = cnt_q;
  assign stat_wce = wce_q;

endmodule

// File: tb/tb_add_loa_pipe.sv
// Scoreboard bench for add_loa_pipe (W=8, K=4, SEG=4, CNT_W=2) driven by directed vectors.
// Expected sums and |err| values are hand-computed; a monitor checks every output cycle.
module tb_add_loa_pipe;

  localparam int W      = 8;
  localparam int K      = 4;
  localparam int SEG    = 4;
  localparam int CNT_W  = 2;
  localparam int P      = W / SEG;
  localparam int CNT_MX = (1 << CNT_W) - 1;

  typedef struct {
    logic [W:0]   sum;
    logic         mode;
    logic [W-1:0] err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_a = '0;
  logic [W-1:0]     in_b = '0;
  logic             in_mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W:0]       out_sum;
  logic             out_mode;
  logic             stat_clr = 1'b0;
  logic [CNT_W-1:0] stat_cnt;
  logic [W-1:0]     stat_wce;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_cnt = 0;
  int   m_wce = 0;

  add_loa_pipe #(.W(W), .K(K), .SEG(SEG), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_mode  (out_mode),
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt),
    .stat_wce  (stat_wce)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: stats against the running model, outputs against the queue head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_sum", 32'(out_sum), 0);
        check("rst_out_mode", 32'(out_mode), 0);
        check("rst_stat_cnt", 32'(stat_cnt), 0);
        check("rst_stat_wce", 32'(stat_wce), 0);
        exp_q.delete();
        m_cnt = 0;
        m_wce = 0;
      end else begin
        check("stat_cnt", 32'(stat_cnt), 32'(m_cnt));
        check("stat_wce", 32'(stat_wce), 32'(m_wce));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_out_valid", 32'(out_valid), 0);
          end else begin
            check(out_ready ? "out_sum" : "out_sum_stalled", 32'(out_sum), 32'(exp_q[0].sum));
            check("out_mode", 32'(out_mode), 32'(exp_q[0].mode));
            if (out_ready) begin
              e = exp_q.pop_front();
              if (e.mode) begin
                if (e.err != 0 && m_cnt != CNT_MX) m_cnt++;
                if (int'(e.err) > m_wce) m_wce = int'(e.err);
              end
            end
          end
        end
        if (stat_clr) begin
          m_cnt = 0;
          m_wce = 0;
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic mode,
                      input logic [W:0] esum, input logic [W-1:0] eerr);
    exp_t e;
    int   w;
    in_a = a; in_b = b; in_mode = mode; in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("in_ready_wait", 32'(in_ready), 1);
      in_valid = 1'b0;
      return;
    end
    e.sum = esum; e.mode = mode; e.err = eerr;
    exp_q.push_back(e);
    n_vec++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    check("drain", exp_q.size(), 0);
    #1;
  endtask

  task automatic check_latency();
    int lat;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, P);
  endtask

  task automatic check_stats(input int cnt, input int wce);
    check("stat_cnt_point", 32'(stat_cnt), 32'(cnt));
    check("stat_wce_point", 32'(stat_wce), 32'(wce));
  endtask

  initial begin : stimulus
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("in_ready_after_reset", 32'(in_ready), 1);

    // Exact add, latency and untouched statistics.
    send(8'd200, 8'd100, 1'b0, 9'h12C, 8'd0);
    check_latency();
    drain();
    check_stats(0, 0);

    // LOA corners.
    send(8'h0F, 8'h01, 1'b1, 9'h00F, 8'd1);
    drain();
    check_stats(1, 1);
    send(8'h08, 8'h08, 1'b1, 9'h018, 8'd8);
    send(8'hFF, 8'hFF, 1'b1, 9'h1FF, 8'd1);
    drain();
    check_stats(3, 8);

    // Backpressure: six back-to-back inputs, out_ready low for five cycles.
    out_ready = 1'b0;
    fork
      begin
        send(8'h01, 8'h02, 1'b0, 9'h003, 8'd0);
        send(8'hFF, 8'h01, 1'b0, 9'h100, 8'd0);
        send(8'h35, 8'h4A, 1'b1, 9'h07F, 8'd0);
        send(8'h9C, 8'h6E, 1'b1, 9'h10E, 8'd4);
        send(8'h80, 8'h80, 1'b0, 9'h100, 8'd0);
        send(8'h23, 8'h14, 1'b1, 9'h037, 8'd0);
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in_ready_full", 32'(in_ready), 0);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check_stats(3, 8);

    // Clear alone, then saturate the 2-bit counter with five error results.
    stat_clr = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    check_stats(0, 0);
    send(8'h0F, 8'h01, 1'b1, 9'h00F, 8'd1);
    send(8'h9C, 8'h6E, 1'b1, 9'h10E, 8'd4);
    send(8'hFF, 8'hFF, 1'b1, 9'h1FF, 8'd1);
    send(8'h08, 8'h08, 1'b1, 9'h018, 8'd8);
    send(8'h0F, 8'h01, 1'b1, 9'h00F, 8'd1);
    drain();
    check_stats(CNT_MX, 8);

    // Clear on the same edge as an error handshake.
    out_ready = 1'b0;
    send(8'h08, 8'h08, 1'b1, 9'h018, 8'd8);
    begin
      int w;
      w = 0;
      while (!out_valid && w < 20) begin
        @(posedge clk);
        #1;
        w++;
      end
      check("stalled_result_ready", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    stat_clr  = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    check_stats(0, 0);
    check("clr_handshake_consumed", exp_q.size(), 0);

    // Reset with two transactions in flight.
    send(8'h0F, 8'h01, 1'b1, 9'h00F, 8'd1);
    drain();
    check_stats(1, 1);
    send(8'h0F, 8'h01, 1'b1, 9'h00F, 8'd1);
    send(8'h08, 8'h08, 1'b1, 9'h018, 8'd8);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 0);
    check("async_rst_out_sum", 32'(out_sum), 0);
    check("async_rst_out_mode", 32'(out_mode), 0);
    check_stats(0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'h55, 8'hAA, 1'b0, 9'h0FF, 8'd0);
    check_latency();
    drain();
    check_stats(0, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/add_loa_pipe.md
# add_loa_pipe

Parametrised, pipelined lower-part-OR (LOA) approximate adder with per-transaction exact/approximate mode, valid/ready flow control and on-line error statistics. It is the clocked, width-generic successor to the fixed 8-bit combinational approximate adders in the adders library. It sits between operand producers and accelerator datapaths that trade accuracy for power at run time. The error counters mirror the library's EP/WCE metrics in hardware.

## Interface
Parameters:
- W, 8: operand width; must be a multiple of SEG.
- K, 4: number of approximated LSBs, 0..W-1; K=0 makes approximate mode exact.
- SEG, 4: bits added per pipeline stage; P = W/SEG stages.
- CNT_W, 16: error-event counter width.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  block accepts a transaction this cycle.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_mode  in  1  0 = exact, 1 = LOA approximate.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  W+1  sum, including carry-out as MSB.
- out_mode  out  1  mode of the transaction on out_sum.
- stat_clr  in  1  synchronous clear of the statistics.
- stat_cnt  out  CNT_W  count of approximate results with nonzero error; saturating.
- stat_wce  out  W  maximum |error| seen since reset or clear.

## Operation
- Exact mode: out_sum = in_a + in_b, W+1 bits, no truncation.
- LOA mode, bits i<K: sum_i = a_i | b_i, and no carry propagates within the low part.
- LOA mode, carry into bit K: c = a_{K-1} & b_{K-1}, or 0 when K=0.
- LOA mode, bits i>=K: exact ripple addition with carry-in c.
- Error metric is computed at stage 0 and travels as sideband; no duplicate exact adder:
  - d = (a & b)[K-1:0].
  - |err| = c ? 2^K - d : d.
  - |err| is at most 2^(K-1).
- Statistics update on each output handshake (out_valid & out_ready) with out_mode=1:
  - stat_cnt increments if |err| != 0 and saturates at 2^CNT_W-1.
  - stat_wce = max(stat_wce, |err|).
- Exact-mode handshakes never touch the statistics.
- stat_clr has priority over an update in the same cycle; both counters become 0.

## Timing
- Pipeline:
  - Stage s adds bits [s*SEG +: SEG] with the carry registered from stage s-1.
  - Unused upper operand bits, mode and |err| are delayed alongside.
  - Latency is P cycles from input handshake to out_valid; with W=8 and SEG=4 that is 2 cycles.
- Flow control: one global enable, en = !out_valid | out_ready.
  - in_ready = en; this is combinational from out_ready.
  - All stages advance when en=1 and hold when en=0.
  - A bubble is inserted when in_valid=0.
- Throughput is one result per cycle when out_ready=1. There is no loss or reordering under any backpressure pattern.
- out_sum and out_mode are stable while out_valid=1 and out_ready=0.
- Reset values: out_valid=0, out_sum=0, out_mode=0, stat_cnt=0, stat_wce=0, all stage valid bits 0.
- in_ready is 1 after reset, since the pipe is empty.
- Assertion of rst_n low mid-stream discards all in-flight transactions immediately.

## Structure
- Package add_loa_pkg holds:
  - the mode constants MODE_EXACT=0 and MODE_LOA=1;
  - the function loa_abs_err(a_low, b_low, K);
  - the parameter legality checks, elaborated as fatal errors (W%SEG, K<W).
- Sub-module add_loa_seg: a combinational SEG-bit slice.
  - Inputs: a, b, cin, and a per-bit approximate mask (bit i masked when mode=1 and global index < K).
  - The slice injects c at global bit K.
  - Outputs: sum and cout.
- The top module instantiates P slices plus the pipeline registers and the statistics logic.

## Test plan
- Exact add, W=8: A=200, B=100, mode 0 -> out_sum=300 (0x12C) exactly 2 cycles after the handshake; statistics unchanged.
- LOA, K=4: A=0x0F, B=0x01 -> out_sum=0x0F (exact 16), |err|=1, stat_cnt=1, stat_wce=1.
- LOA, K=4: A=0x08, B=0x08 -> out_sum=0x18 (exact 16), |err|=8=2^(K-1), stat_wce=8; a following A=B=0xFF in LOA mode gives out_sum=0x1FF.
- Backpressure: 6 back-to-back inputs with out_ready low for 5 cycles.
  - in_ready drops once the pipe is full.
  - All 6 results emerge in order, unchanged.
  - out_sum holds while stalled.
- Statistics corners, CNT_W=2: 5 nonzero-error LOA results -> stat_cnt saturates at 3.
  - stat_clr asserted on the same cycle as an error handshake -> stat_cnt=0 and stat_wce=0.
- Reset mid-stream: rst_n low with 2 transactions in flight.
  - out_valid=0 and all outputs are 0 asynchronously.
  - After release, the first new input yields its result after P cycles with no stale data.
